mem_store_rmw: RTL and testbench
================================

Name: mem_store_rmw

Overview:
- Sits between the EX/MEM pipeline register and the MEM stage. It turns sub-word stores (SB/SH) into a word read-modify-write so that neighbouring bytes in the byte-addressed data RAM are preserved.
- Loads, SW and idle cycles pass straight through to MEM.
- While an RMW sequence is in progress, the block raises a stall towards the hazard unit.

Parameters:
- NB_WIDTH, 32, data/address line width.
- NB_CNT, 16, width of the RMW event counter.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  EX/MEM slot holds a live instruction.
- i_flush  in  1  kill the request presented this cycle.
- i_addr  in  NB_WIDTH  byte address from ALU.
- i_wdata  in  NB_WIDTH  store data (rt).
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_bhw  in  3  size code: 000 B, 001 H, 011 W, 100 BU, 101 HU.
- i_mem_rdata  in  NB_WIDTH  combinational read word from RAM at o_mem_addr. Bytes addr..addr+3; byte at addr is in [7:0].
- o_mem_addr  out  NB_WIDTH  address to MEM.
- o_mem_data  out  NB_WIDTH  write data to MEM.
- o_mem_read  out  1  read enable to MEM.
- o_mem_write  out  1  write enable to MEM.
- o_bhw  out  3  size code to MEM.
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- o_addr_err  out  1  one-cycle misalignment pulse (optional feature).
- o_rmw_count  out  NB_CNT  saturating count of completed RMW writes.

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset i_reset_n is asynchronous and active-low.
  - Reset sets state=IDLE, r_addr=0, r_merge=0, o_rmw_count=0, and the error flop to 0.
  - While reset is asserted, o_mem_read, o_mem_write, o_stall and o_addr_err are forced to 0. All other outputs are 0.
- Request qualification: req = i_valid & ~i_flush.
- State machine has two states: IDLE and RMW_WR.
- IDLE, no sub-word store (load, SW, or bubble): pure combinational pass-through, zero added latency.
  - o_mem_addr=i_addr, o_mem_data=i_wdata, o_bhw=i_bhw.
  - o_mem_read=req&i_mem_read, o_mem_write=req&i_mem_write, o_stall=0.
- IDLE, sub-word store (req & i_mem_write & i_bhw in {000,001}):
  - Drive o_mem_addr=i_addr, o_mem_read=1, o_mem_write=0, o_bhw=011, o_stall=1.
  - At the clock edge, latch r_addr=i_addr.
  - At the same edge, latch r_merge: SB gives {i_mem_rdata[31:8], i_wdata[7:0]}; SH gives {i_mem_rdata[31:16], i_wdata[15:0]}.
  - Next state is RMW_WR.
- RMW_WR:
  - Drive o_mem_addr=r_addr, o_mem_data=r_merge, o_mem_write=1, o_mem_read=0, o_bhw=011, o_stall=0.
  - Increment o_rmw_count, saturating at all-ones.
  - Next state is IDLE.
  - Inputs are ignored in this state. Upstream still holds the same store because the previous cycle stalled; when the stall drops, EX/MEM advances.
- RMW_WR is committed: i_flush and i_valid are ignored in RMW_WR. A flush only cancels a request seen in IDLE.
- Latency:
  - SB/SH: exactly 1 stall cycle, with the write on the 2nd cycle.
  - All other operations: 0 stall cycles.
- Back-to-back SB: after RMW_WR, the FSM returns to IDLE. The next SB stalls 1 cycle and reads memory as updated by the previous write (the write occurs at the RMW_WR edge).
- i_mem_read & i_mem_write both high is illegal. The block treats it as a store; loads are never combined with RMW.
- Address wrap: no wrap handling. The RAM truncates the address to its width.
- Reset asserted during RMW_WR: the write is abandoned and the FSM returns to IDLE immediately (asynchronous).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned when H/HU/SH has i_addr[0]=1, or W/SW has i_addr[1:0]!=00.
  - A misaligned access with req in IDLE suppresses o_mem_read/o_mem_write (both 0), does not stall and does not enter RMW.
  - It raises o_addr_err for exactly that cycle via a registered pulse path: the error flop is set at the edge, and o_addr_err is asserted in the same cycle combinationally and cleared next cycle unless repeated.
- Not defined: no checks; o_addr_err is tied to 0; misaligned accesses pass through or RMW normally.

Test Plan:
- Pass-through LW: RAM[0x10..0x13]=0xAABBCCDD, i_addr=0x10, LW, i_valid=1 -> o_mem_read=1, o_stall=0, o_bhw=011 in the same cycle, no state change.
- SB RMW: RAM word at 0x20=0x11223344, SB i_wdata=0x000000EE at 0x20 -> cycle 1: o_stall=1, o_mem_read=1. Cycle 2: o_mem_write=1, o_mem_data=0x112233EE, o_bhw=011. o_rmw_count goes 0->1.
- SH RMW: word 0x55667788 at 0x40, SH data 0x0000BEEF -> cycle 2 writes 0x5566BEEF. Two back-to-back SB to 0x40 then 0x41 -> second read observes the first write; 2 stall cycles in total.
- Flush: SB with i_flush=1 in IDLE -> no stall, no read, no write. Flush asserted during RMW_WR -> write 0x112233EE still issued.
- Async reset mid-RMW: assert i_reset_n=0 during RMW_WR -> o_mem_write drops to 0 immediately, count unchanged, FSM in IDLE after release.
- MEM_ALIGN_CHECK_EN: LW at 0x22 -> o_mem_read=0, o_addr_err=1 for 1 cycle. Same stimulus without the macro -> o_mem_read=1, o_addr_err=0.

Source files
------------

// File: rtl/mem_store_rmw_if.sv
// Bus between the EX/MEM register and the MEM stage, as seen by mem_store_rmw.
// master: pipeline/test side that drives requests and supplies the RAM read word.
// slave:  mem_store_rmw itself.
interface mem_store_rmw_if #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_CNT   = 16
);
  logic                i_valid;
  logic                i_flush;
  logic [NB_WIDTH-1:0] i_addr;
  logic [NB_WIDTH-1:0] i_wdata;
  logic                i_mem_read;
  logic                i_mem_write;
  logic [2:0]          i_bhw;
  logic [NB_WIDTH-1:0] i_mem_rdata;

  logic [NB_WIDTH-1:0] o_mem_addr;
  logic [NB_WIDTH-1:0] o_mem_data;
  logic                o_mem_read;
  logic                o_mem_write;
  logic [2:0]          o_bhw;
  logic                o_stall;
  logic                o_addr_err;
  logic [NB_CNT-1:0]   o_rmw_count;

  modport master (
    output i_valid, i_flush, i_addr, i_wdata, i_mem_read, i_mem_write, i_bhw, i_mem_rdata,
    input  o_mem_addr, o_mem_data, o_mem_read, o_mem_write, o_bhw, o_stall, o_addr_err,
           o_rmw_count
  );

  modport slave (
    input  i_valid, i_flush, i_addr, i_wdata, i_mem_read, i_mem_write, i_bhw, i_mem_rdata,
    output o_mem_addr, o_mem_data, o_mem_read, o_mem_write, o_bhw, o_stall, o_addr_err,
           o_rmw_count
  );
endinterface

// File: rtl/mem_store_rmw.sv
// Sub-word store read-modify-write shim between EX/MEM and the MEM stage.
// SB/SH become a word read (one stall cycle) followed by a merged word write;
// loads, SW and bubbles pass straight through combinationally.
// Optional build macro MEM_ALIGN_CHECK_EN: flags misaligned H/HU/SH and W/SW accesses,
// suppresses their memory enables and pulses o_addr_err for that cycle.
module mem_store_rmw #(
  parameter int unsigned NB_WIDTH = 32,
  parameter int unsigned NB_CNT   = 16
) (
  input logic             i_clk,
  input logic             i_reset_n,
  mem_store_rmw_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e              state_q;
  logic [NB_WIDTH-1:0] r_addr_q;
  logic [NB_WIDTH-1:0] r_merge_q;
  logic [NB_CNT-1:0]   rmw_count_q;

  logic                req;
  logic                misalign;
  logic                sub_store;
  logic [NB_WIDTH-1:0] lane_mask;
  logic [NB_WIDTH-1:0] merge_d;

  assign req = bus.i_valid & ~bus.i_flush;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  // Misalignment of a live request; only acted on while idle.
  always_comb begin
    misalign = 1'b0;
    if (req && (bus.i_mem_read || bus.i_mem_write)) begin
      case (bus.i_bhw)
        3'b001, 3'b101: misalign = bus.i_addr[0];
        3'b011:         misalign = |bus.i_addr[1:0];
        default:        misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // A store wins over a simultaneous read request, so read+write with SB/SH still does RMW.
  assign sub_store = req & bus.i_mem_write & ~misalign &
                     ((bus.i_bhw == 3'b000) || (bus.i_bhw == 3'b001));

  // Byte lanes replaced by the store data: low byte for SB, low half for SH.
  always_comb begin
    lane_mask = bus.i_bhw[0] ? NB_WIDTH'(16'hFFFF) : NB_WIDTH'(8'hFF);
    merge_d   = (bus.i_mem_rdata & ~lane_mask) | (bus.i_wdata & lane_mask);
  end

  // FSM, captured RMW address/word and saturating RMW counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      r_addr_q    <= '0;
      r_merge_q   <= '0;
      rmw_count_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      err_q <= misalign & (state_q == StIdle);
`endif
      unique case (state_q)
        StIdle: begin
          if (sub_store) begin
            state_q   <= StRmwWr;
            r_addr_q  <= bus.i_addr;
            r_merge_q <= merge_d;
          end
        end
        StRmwWr: begin
          // Committed write: inputs, including flush, are ignored here.
          state_q <= StIdle;
          if (rmw_count_q != {NB_CNT{1'b1}}) begin
            rmw_count_q <= rmw_count_q + NB_CNT'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output steering; everything is held at zero while reset is asserted.
  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_data  = '0;
    bus.o_mem_read  = 1'b0;
    bus.o_mem_write = 1'b0;
    bus.o_bhw       = 3'b000;
    bus.o_stall     = 1'b0;
    bus.o_addr_err  = 1'b0;
    if (i_reset_n) begin
      if (state_q == StRmwWr) begin
        bus.o_mem_addr  = r_addr_q;
        bus.o_mem_data  = r_merge_q;
        bus.o_mem_write = 1'b1;
        bus.o_bhw       = 3'b011;
      end else if (misalign) begin
        bus.o_mem_addr  = bus.i_addr;
        bus.o_mem_data  = bus.i_wdata;
        bus.o_bhw       = bus.i_bhw;
        bus.o_addr_err  = 1'b1;
      end else if (sub_store) begin
        bus.o_mem_addr  = bus.i_addr;
        bus.o_mem_data  = bus.i_wdata;
        bus.o_mem_read  = 1'b1;
        bus.o_bhw       = 3'b011;
        bus.o_stall     = 1'b1;
      end else begin
        bus.o_mem_addr  = bus.i_addr;
        bus.o_mem_data  = bus.i_wdata;
        bus.o_bhw       = bus.i_bhw;
        bus.o_mem_read  = req & bus.i_mem_read & ~bus.i_mem_write;
        bus.o_mem_write = req & bus.i_mem_write;
      end
    end
  end

  assign bus.o_rmw_count = rmw_count_q;

endmodule

// File: tb/tb_mem_store_rmw.sv
// Self-checking bench for mem_store_rmw: byte RAM model driven by the DUT's outputs,
// directed scenarios plus randomized ops checked against a byte-array reference.
module tb_mem_store_rmw;

  localparam int unsigned CntW = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mem_store_rmw_if #(.NB_WIDTH(32), .NB_CNT(CntW)) bus ();

  mem_store_rmw #(.NB_WIDTH(32), .NB_CNT(CntW)) u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed RAM, 256 bytes, address truncated to 8 bits.
  logic [7:0]  ram [256];
  logic        ram_init;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_word;
  logic [7:0]  ra;

  assign ra = bus.o_mem_addr[7:0];
  assign bus.i_mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (pl_en) begin
      for (int k = 0; k < 4; k++) ram[pl_addr + 8'(k)] <= pl_word[8*k +: 8];
    end else if (bus.o_mem_write) begin
      case (bus.o_bhw)
        3'b000, 3'b100: ram[ra] <= bus.o_mem_data[7:0];
        3'b001, 3'b101: begin
          ram[ra]         <= bus.o_mem_data[7:0];
          ram[ra + 8'd1]  <= bus.o_mem_data[15:8];
        end
        default: for (int k = 0; k < 4; k++) ram[ra + 8'(k)] <= bus.o_mem_data[8*k +: 8];
      endcase
    end
  end

  // Reference model state.
  logic [7:0]      ref_mem [256];
  logic [CntW-1:0] cnt_m;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ram_word(input logic [7:0] b);
    return {ram[b + 8'd3], ram[b + 8'd2], ram[b + 8'd1], ram[b]};
  endfunction

  // Architectural effect of one op: memory bytes, counter, and what MEM should see.
  task automatic model_op(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] bhw,
                          input logic rd, input logic wr, input logic fl,
                          output int e_stalls, output logic e_rd, output logic e_err,
                          output logic e_wrote, output logic [31:0] e_wdata);
    logic live, mis, sub;
    live = !fl;
    sub  = wr && (bhw == 3'b000 || bhw == 3'b001);
    mis  = 1'b0;
    if (AlignEn && live && (rd || wr)) begin
      if (bhw == 3'b001 || bhw == 3'b101) mis = a[0];
      else if (bhw == 3'b011)             mis = (a[1:0] != 2'b00);
    end
    e_err    = mis;
    e_rd     = live && !mis && ((rd && !wr) || sub);
    e_wrote  = live && !mis && wr;
    e_stalls = (e_wrote && sub) ? 1 : 0;
    if (e_wrote) begin
      if (bhw == 3'b000) begin
        ref_mem[a[7:0]] = wd[7:0];
      end else if (bhw == 3'b001) begin
        ref_mem[a[7:0]]        = wd[7:0];
        ref_mem[a[7:0] + 8'd1] = wd[15:8];
      end else begin
        for (int k = 0; k < 4; k++) ref_mem[a[7:0] + 8'(k)] = wd[8*k +: 8];
      end
      if (sub && cnt_m != {CntW{1'b1}}) cnt_m = cnt_m + 1'b1;
    end
    e_wdata = ref_word(a);
  endtask

  task automatic drive_idle();
    bus.i_valid     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_addr      = '0;
    bus.i_wdata     = '0;
    bus.i_mem_read  = 1'b0;
    bus.i_mem_write = 1'b0;
    bus.i_bhw       = 3'b000;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    @(negedge clk);
    drive_idle();
    pl_en = 1'b1; pl_addr = a; pl_word = w;
    for (int k = 0; k < 4; k++) ref_mem[a + 8'(k)] = w[8*k +: 8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present one op and hold it while the DUT stalls; returns what MEM saw.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] bhw,
                       input logic rd, input logic wr, input logic fl,
                       output int stalls, output logic f_rd, output logic f_err,
                       output logic [31:0] f_rdata, output logic wrote,
                       output logic [31:0] w_addr, output logic [31:0] w_data,
                       output logic [2:0] w_bhw);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_flush = fl; bus.i_addr = a; bus.i_wdata = wd;
    bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_bhw = bhw;
    stalls = 0; wrote = 1'b0; w_addr = '0; w_data = '0; w_bhw = '0;
    #1;
    f_rd = bus.o_mem_read; f_err = bus.o_addr_err; f_rdata = bus.i_mem_rdata;
    for (int c = 0; c < 4; c++) begin
      if (bus.o_mem_write) begin
        wrote = 1'b1; w_addr = bus.o_mem_addr; w_data = bus.o_mem_data; w_bhw = bus.o_bhw;
      end
      if (!bus.o_stall) break;
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 4) begin
      n_cmp++; n_fail++;
      $display("FAIL stall_timeout: stalled %0d cycles, required at most 1", stalls);
    end
    @(posedge clk);
  endtask

  task automatic check_count(input string tag);
    #1;
    n_cmp++;
    if (bus.o_rmw_count !== cnt_m) begin
      n_fail++;
      $display("FAIL %s count: got %0d, required %0d", tag, bus.o_rmw_count, cnt_m);
    end
  endtask

  // Shared locals for scenarios.
  int          st;
  logic        frd, ferr, wr_seen;
  logic [31:0] frdata, waddr, wdata;
  logic [2:0]  wbhw;
  int          e_st;
  logic        e_rd, e_err, e_wr;
  logic [31:0] e_wd;

  task automatic test_reset();
    bus.i_valid = 1'b1; bus.i_addr = 32'h10; bus.i_mem_read = 1'b1; bus.i_bhw = 3'b011;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.o_mem_read, bus.o_mem_write, bus.o_stall, bus.o_addr_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd/wr/stall/err=%b, required 0000",
               {bus.o_mem_read, bus.o_mem_write, bus.o_stall, bus.o_addr_err});
    end
    n_cmp++;
    if (bus.o_mem_addr !== 32'h0 || bus.o_rmw_count !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h count=%0d, required 0 and 0",
               bus.o_mem_addr, bus.o_rmw_count);
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_addr = 32'h60; bus.i_wdata = 32'hA5;
    bus.i_mem_write = 1'b1; bus.i_bhw = 3'b000;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.o_mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre_write: o_mem_write=%b, required 1", bus.o_mem_write);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_mem_write !== 1'b0 || bus.o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_drop: wr=%b stall=%b, required 0 0", bus.o_mem_write, bus.o_stall);
    end
    drive_idle();
    #1 rst_n = 1'b1;
    check_count("arst");
    // RAM at 0x60 must be untouched.
    n_cmp++;
    if (ram_word(8'h60) !== ref_word(32'h60)) begin
      n_fail++;
      $display("FAIL arst_ram: got %h, required %h", ram_word(8'h60), ref_word(32'h60));
    end
    issue(32'h60, 0, 3'b011, 1, 0, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
    n_cmp++;
    if (st !== 0 || frd !== 1'b1 || wr_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_idle_after: stalls=%0d rd=%b wr=%b, required 0 1 0", st, frd, wr_seen);
    end
  endtask

  task automatic test_lw_passthrough();
    preload(8'h10, 32'hAABBCCDD);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_addr = 32'h10; bus.i_mem_read = 1'b1; bus.i_bhw = 3'b011;
    #1;
    n_cmp++;
    if (bus.o_mem_read !== 1'b1 || bus.o_stall !== 1'b0 || bus.o_bhw !== 3'b011 ||
        bus.o_mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL lw_pass: rd=%b stall=%b bhw=%b addr=%h, required 1 0 011 00000010",
               bus.o_mem_read, bus.o_stall, bus.o_bhw, bus.o_mem_addr);
    end
    n_cmp++;
    if (bus.i_mem_rdata !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL lw_data: got %h, required aabbccdd", bus.i_mem_rdata);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if (bus.o_stall !== 1'b0 || bus.o_mem_write !== 1'b0 || bus.o_mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_no_state: stall=%b wr=%b rd=%b, required 0 0 0",
               bus.o_stall, bus.o_mem_write, bus.o_mem_read);
    end
  endtask

  task automatic test_sb_rmw();
    preload(8'h20, 32'h11223344);
    check_count("sb_before");
    issue(32'h20, 32'hEE, 3'b000, 0, 1, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
    model_op(32'h20, 32'hEE, 3'b000, 0, 1, 0, e_st, e_rd, e_err, e_wr, e_wd);
    n_cmp++;
    if (st !== 1 || frd !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_cycle1: stalls=%0d rd=%b, required 1 1", st, frd);
    end
    n_cmp++;
    if (wr_seen !== 1'b1 || wdata !== 32'h112233EE || wbhw !== 3'b011 || waddr !== 32'h20) begin
      n_fail++;
      $display("FAIL sb_write: wr=%b data=%h bhw=%b addr=%h, required 1 112233ee 011 00000020",
               wr_seen, wdata, wbhw, waddr);
    end
    check_count("sb_after");
  endtask

  task automatic test_sh_back_to_back();
    preload(8'h40, 32'h55667788);
    issue(32'h40, 32'hBEEF, 3'b001, 0, 1, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
    model_op(32'h40, 32'hBEEF, 3'b001, 0, 1, 0, e_st, e_rd, e_err, e_wr, e_wd);
    n_cmp++;
    if (st !== 1 || wdata !== 32'h5566BEEF) begin
      n_fail++;
      $display("FAIL sh_write: stalls=%0d data=%h, required 1 5566beef", st, wdata);
    end
    begin
      int tot;
      issue(32'h40, 32'h11, 3'b000, 0, 1, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
      model_op(32'h40, 32'h11, 3'b000, 0, 1, 0, e_st, e_rd, e_err, e_wr, e_wd);
      tot = st;
      issue(32'h41, 32'h22, 3'b000, 0, 1, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
      model_op(32'h41, 32'h22, 3'b000, 0, 1, 0, e_st, e_rd, e_err, e_wr, e_wd);
      tot += st;
      n_cmp++;
      if (tot !== 2) begin
        n_fail++;
        $display("FAIL b2b_stalls: got %0d, required 2", tot);
      end
      n_cmp++;
      if (wdata !== e_wd) begin
        n_fail++;
        $display("FAIL b2b_second_write: got %h, required %h", wdata, e_wd);
      end
      #1;
      n_cmp++;
      if (ram_word(8'h40) !== 32'h55662211) begin
        n_fail++;
        $display("FAIL b2b_ram: got %h, required 55662211", ram_word(8'h40));
      end
    end
    check_count("b2b");
  endtask

  task automatic test_flush();
    preload(8'h20, 32'h11223344);
    issue(32'h20, 32'hEE, 3'b000, 0, 1, 1, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
    n_cmp++;
    if (st !== 0 || frd !== 1'b0 || wr_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: stalls=%0d rd=%b wr=%b, required 0 0 0", st, frd, wr_seen);
    end
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_flush = 1'b0; bus.i_addr = 32'h20; bus.i_wdata = 32'hEE;
    bus.i_mem_write = 1'b1; bus.i_bhw = 3'b000;
    @(negedge clk);
    bus.i_flush = 1'b1; bus.i_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_mem_write !== 1'b1 || bus.o_mem_data !== 32'h112233EE) begin
      n_fail++;
      $display("FAIL flush_in_rmw: wr=%b data=%h, required 1 112233ee",
               bus.o_mem_write, bus.o_mem_data);
    end
    model_op(32'h20, 32'hEE, 3'b000, 0, 1, 0, e_st, e_rd, e_err, e_wr, e_wd);
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if (ram_word(8'h20) !== 32'h112233EE) begin
      n_fail++;
      $display("FAIL flush_ram: got %h, required 112233ee", ram_word(8'h20));
    end
    check_count("flush");
  endtask

  task automatic test_align();
    issue(32'h22, 0, 3'b011, 1, 0, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
    n_cmp++;
    if (frd !== !AlignEn || ferr !== AlignEn || st !== 0) begin
      n_fail++;
      $display("FAIL align_lw22: rd=%b err=%b stalls=%0d, required %b %b 0",
               frd, ferr, st, !AlignEn, AlignEn);
    end
    issue(32'h24, 0, 3'b011, 1, 0, 0, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
    n_cmp++;
    if (frd !== 1'b1 || ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL align_clear: rd=%b err=%b, required 1 0", frd, ferr);
    end
  endtask

  task automatic test_random();
    logic [2:0]  codes [8];
    logic [31:0] a, wd;
    logic        rd, wr, fl;
    int          k;
    codes = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b000, 3'b001, 3'b011};
    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 7);
      a  = $urandom;
      wd = $urandom;
      wr = (k >= 5);
      rd = !wr;
      fl = ($urandom_range(0, 4) == 0);
      issue(a, wd, codes[k], rd, wr, fl, st, frd, ferr, frdata, wr_seen, waddr, wdata, wbhw);
      model_op(a, wd, codes[k], rd, wr, fl, e_st, e_rd, e_err, e_wr, e_wd);
      n_cmp++;
      if (st !== e_st || frd !== e_rd || ferr !== e_err || wr_seen !== e_wr) begin
        n_fail++;
        $display("FAIL rnd_ctrl[%0d]: stall/rd/err/wr=%0d %b %b %b, required %0d %b %b %b",
                 n, st, frd, ferr, wr_seen, e_st, e_rd, e_err, e_wr);
      end
      if (e_wr) begin
        n_cmp++;
        if (wdata !== e_wd || waddr !== a || wbhw !== 3'b011) begin
          n_fail++;
          $display("FAIL rnd_write[%0d]: data=%h addr=%h bhw=%b, required %h %h 011",
                   n, wdata, waddr, wbhw, e_wd, a);
        end
      end
      if (e_rd && rd) begin
        n_cmp++;
        if (frdata !== e_wd) begin
          n_fail++;
          $display("FAIL rnd_load[%0d]: ram word %h, required %h", n, frdata, e_wd);
        end
      end
      check_count("rnd");
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; ram_init = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_word = '0;
    cnt_m = '0;
    drive_idle();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    test_reset();
    test_async_reset();
    test_lw_passthrough();
    test_sb_rmw();
    test_sh_back_to_back();
    test_flush();
    test_align();
    test_random();
    @(negedge clk);
    drive_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
